// File: rtl/membus_arbiter_ctl_if.sv
// ---------------------------------------------------------------------------
// membus_arbiter_ctl_if
// Shared common-bus signal bundle between the CPU-side access controller
// (membus_arbiter_ctl) and the system bus / system arbiter.
//
// Signals:
//   bus_req    master->slave  bus request to the system arbiter
//   bus_gnt    slave->master  bus grant, held while bus_req=1
//   bus_stb    master->slave  transfer strobe
//   bus_wr     master->slave  1=write, 0=read; valid while bus_stb
//   bus_addr   master->slave  AW-bit transfer address
//   bus_wdata  master->slave  DW-bit transfer write data
//   bus_rdata  slave->master  DW-bit read data, valid with bus_ack
//   bus_ack    slave->master  transfer acknowledge
//
// Modports:
//   master  the access controller side
//   slave   the system bus / memory side
// ---------------------------------------------------------------------------
interface membus_arbiter_ctl_if #(
  parameter int AW = 21,
  parameter int DW = 72
);
  logic          bus_req;
  logic          bus_gnt;
  logic          bus_stb;
  logic          bus_wr;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;

  modport master (
    output bus_req, bus_stb, bus_wr, bus_addr, bus_wdata,
    input  bus_gnt, bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_stb, bus_wr, bus_addr, bus_wdata,
    output bus_gnt, bus_rdata, bus_ack
  );
endinterface

// File: rtl/membus_arbiter_ctl.sv
// ---------------------------------------------------------------------------
// membus_arbiter_ctl
// Common-bus access controller downstream of the CPU microengine. Accepts an
// arbiter opcode (ARBOPC) with address and write data, runs one transaction
// on the shared bus via request/grant/strobe/acknowledge, and returns read
// data plus the ARBRDY condition polled by the microsequencer.
//
// Opcodes: 0 NOP, 1 READ, 2 WRITE, 3 READ_LOCK, 4 UNLOCK, 5-15 illegal.
// A READ_LOCK keeps the bus (bus_req stays high) so following accesses skip
// the request phase until an UNLOCK.
//
// Parameters:
//   AW   physical address width (10-bit page + 11-bit offset)
//   DW   data width (64 data + 8 tag)
//   TMO  bus timeout in clocks, used only when ARB_TIMEOUT_EN is defined
//
// Optional feature macro: ARB_TIMEOUT_EN
//   Defined:   a transaction stuck in REQ or XFER for TMO clocks is aborted,
//              sets err, drops the bus (including any lock) and returns
//              all-ones read data on a read.
//   Undefined: the block waits indefinitely for grant/acknowledge.
//
// Ports:
//   clk      clock
//   reset    asynchronous active-high reset
//   start    one-cycle command strobe (ARBI decode)
//   opc      arbiter opcode, sampled with start
//   addr     physical address, sampled with start
//   wdata    write data, sampled with start
//   err_clr  clears the sticky error flag (a coincident new error wins)
//   rdy      ARBRDY: idle and ready to accept start
//   rdata    last read data, held until the next completed read
//   err      sticky error flag
//   locked   bus lock held
//   bus      membus_arbiter_ctl_if.master shared-bus bundle
// All outputs are registered.
// ---------------------------------------------------------------------------
module membus_arbiter_ctl #(
  parameter int AW  = 21,
  parameter int DW  = 72,
  parameter int TMO = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           opc,
  input  logic [AW-1:0]        addr,
  input  logic [DW-1:0]        wdata,
  input  logic                 err_clr,
  output logic                 rdy,
  output logic [DW-1:0]        rdata,
  output logic                 err,
  output logic                 locked,
  membus_arbiter_ctl_if.master bus
);

  localparam logic [3:0] OPC_NOP       = 4'd0;
  localparam logic [3:0] OPC_READ      = 4'd1;
  localparam logic [3:0] OPC_WRITE     = 4'd2;
  localparam logic [3:0] OPC_READ_LOCK = 4'd3;
  localparam logic [3:0] OPC_UNLOCK    = 4'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Command latches captured when a bus opcode is accepted.
  logic [3:0]    r_opc;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  // Registered outputs.
  logic          r_rdy;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic          r_locked;
  logic          r_req;
  logic          r_stb;
  logic          r_wr;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;

  // Next values of the registers above.
  logic [3:0]    w_opc;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_rdy;
  logic [DW-1:0] w_rdata;
  logic          w_err;
  logic          w_err_set;
  logic          w_locked;
  logic          w_req;
  logic          w_stb;
  logic          w_wr;
  logic [AW-1:0] w_bus_addr;
  logic [DW-1:0] w_bus_wdata;

  logic          w_cmd_ok;    // command accepted this cycle
  logic          w_opc_bus;   // opcode needs a bus transaction
  logic          w_lat_read;  // latched opcode is a read
  logic          w_timeout;   // abort the current transaction

  assign w_cmd_ok   = (r_state == S_IDLE) && start && r_rdy;
  assign w_opc_bus  = (opc == OPC_READ) || (opc == OPC_WRITE) ||
                      (opc == OPC_READ_LOCK);
  assign w_lat_read = (r_opc == OPC_READ) || (r_opc == OPC_READ_LOCK);

`ifdef ARB_TIMEOUT_EN
  // Counter is at least 8 bits wide and large enough to hold TMO.
  localparam int CW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;

  logic [CW-1:0] r_cnt;
  logic          w_enter_busy;

  assign w_enter_busy = (w_state_nxt != r_state) && (w_state_nxt != S_IDLE);

  // A grant or acknowledge arriving in the same cycle as the limit wins.
  assign w_timeout = (r_cnt == CW'(TMO)) &&
                     (((r_state == S_REQ)  && !bus.bus_gnt) ||
                      ((r_state == S_XFER) && !bus.bus_ack));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_enter_busy) begin
      r_cnt <= '0;
    end else if (r_state != S_IDLE) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_cmd_ok && w_opc_bus) begin
          // Under lock the grant is already held: skip the request phase.
          w_state_nxt = r_locked ? S_XFER : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.bus_gnt) begin
          w_state_nxt = S_XFER;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_XFER: begin
        if (bus.bus_ack || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output / datapath next-value logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_opc       = r_opc;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_rdy       = r_rdy;
    w_rdata     = r_rdata;
    w_err_set   = 1'b0;
    w_locked    = r_locked;
    w_req       = r_req;
    w_stb       = r_stb;
    w_wr        = r_wr;
    w_bus_addr  = r_bus_addr;
    w_bus_wdata = r_bus_wdata;

    case (r_state)
      S_IDLE: begin
        if (w_cmd_ok) begin
          if (w_opc_bus) begin
            w_opc   = opc;
            w_addr  = addr;
            w_wdata = wdata;
            w_rdy   = 1'b0;
            if (r_locked) begin
              // Direct to transfer; the latches are loading these same
              // values, so drive the bus from the command inputs.
              w_stb       = 1'b1;
              w_wr        = (opc == OPC_WRITE);
              w_bus_addr  = addr;
              w_bus_wdata = wdata;
            end else begin
              w_req = 1'b1;
            end
          end else if (opc == OPC_UNLOCK) begin
            w_locked = 1'b0;
            w_req    = 1'b0;
          end else if (opc != OPC_NOP) begin
            w_err_set = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (bus.bus_gnt) begin
          w_stb       = 1'b1;
          w_wr        = (r_opc == OPC_WRITE);
          w_bus_addr  = r_addr;
          w_bus_wdata = r_wdata;
        end
      end
      S_XFER: begin
        if (bus.bus_ack) begin
          if (w_lat_read) begin
            w_rdata = bus.bus_rdata;
          end
          w_stb = 1'b0;
          w_rdy = 1'b1;
          if (r_opc == OPC_READ_LOCK) begin
            // Keep the bus: bus_req stays asserted while locked.
            w_locked = 1'b1;
          end else if (!r_locked) begin
            w_req = 1'b0;
          end
        end
      end
      default: ;
    endcase

    // Abort releases the bus entirely, including any lock.
    if (w_timeout) begin
      w_req     = 1'b0;
      w_stb     = 1'b0;
      w_locked  = 1'b0;
      w_err_set = 1'b1;
      w_rdy     = 1'b1;
      if (w_lat_read) begin
        w_rdata = '1;
      end
    end
  end

  // Sticky error: a new error takes priority over a coincident clear.
  assign w_err = w_err_set | (r_err & ~err_clr);

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state     <= S_IDLE;
      r_opc       <= OPC_NOP;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdy       <= 1'b1;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
      r_req       <= 1'b0;
      r_stb       <= 1'b0;
      r_wr        <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_opc       <= w_opc;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_rdy       <= w_rdy;
      r_rdata     <= w_rdata;
      r_err       <= w_err;
      r_locked    <= w_locked;
      r_req       <= w_req;
      r_stb       <= w_stb;
      r_wr        <= w_wr;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
    end
  end

  assign rdy           = r_rdy;
  assign rdata         = r_rdata;
  assign err           = r_err;
  assign locked        = r_locked;
  assign bus.bus_req   = r_req;
  assign bus.bus_stb   = r_stb;
  assign bus.bus_wr    = r_wr;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_membus_arbiter_ctl.sv
// ---------------------------------------------------------------------------
// tb_membus_arbiter_ctl
// Self-checking bench for membus_arbiter_ctl. Each transaction is described
// by its grant delay and acknowledge delay; the expected waveform of every
// output is derived from those delays by cycle arithmetic and checked on
// every falling edge. Literal expectations pin latency, lock, error and
// reset behaviour.
// ---------------------------------------------------------------------------
module tb_membus_arbiter_ctl;

  localparam int AW = 21;
  localparam int DW = 72;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    opc;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          err_clr;
  logic          rdy;
  logic [DW-1:0] rdata;
  logic          err;
  logic          locked;

  membus_arbiter_ctl_if #(.AW(AW), .DW(DW)) bus ();

  membus_arbiter_ctl #(.AW(AW), .DW(DW), .TMO(255)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .opc     (opc),
    .addr    (addr),
    .wdata   (wdata),
    .err_clr (err_clr),
    .rdy     (rdy),
    .rdata   (rdata),
    .err     (err),
    .locked  (locked),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected outputs for the current cycle.
  bit            chk_en = 1'b0;
  logic          exp_rdy, exp_req, exp_stb, exp_wr, exp_err, exp_locked;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata, exp_rdata;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic set_reset_exp();
    exp_rdy    = 1'b1;
    exp_req    = 1'b0;
    exp_stb    = 1'b0;
    exp_wr     = 1'b0;
    exp_err    = 1'b0;
    exp_locked = 1'b0;
    exp_addr   = '0;
    exp_wdata  = '0;
    exp_rdata  = '0;
  endtask

  // Compare process: every cycle, outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdy",    DW'(rdy),         DW'(exp_rdy));
      check("req",    DW'(bus.bus_req), DW'(exp_req));
      check("stb",    DW'(bus.bus_stb), DW'(exp_stb));
      check("err",    DW'(err),         DW'(exp_err));
      check("locked", DW'(locked),      DW'(exp_locked));
      check("rdata",  rdata,            exp_rdata);
      if (exp_stb) begin
        check("bus_wr",    DW'(bus.bus_wr),   DW'(exp_wr));
        check("bus_addr",  DW'(bus.bus_addr), DW'(exp_addr));
        check("bus_wdata", bus.bus_wdata,     exp_wdata);
      end
    end
  end

  // One bus transaction (opcode 1/2/3). Entered just after a rising edge;
  // returns just after the rising edge that makes rdy high again (that
  // cycle doubles as the next command's cycle 0).
  // gd: REQ cycles before grant; ad: XFER cycles before acknowledge.
  task automatic run_op(input logic [3:0] op, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input int gd, input int ad,
                        input bit fix_rd, input logic [DW-1:0] rd_val,
                        output int lat, output int stbf);
    bit            lk;
    int            stb_s, done;
    logic [DW-1:0] rd;
    lk    = exp_locked;
    stb_s = lk ? 1 : gd + 2;
    done  = stb_s + ad + 1;
    lat   = -1;
    stbf  = -1;
    rd    = '0;
    start = 1'b1; opc = op; addr = a; wdata = d; err_clr = 1'b0;
    bus.bus_gnt   = 1'($urandom_range(0, 1));
    bus.bus_ack   = 1'($urandom_range(0, 1));
    bus.bus_rdata = rand_dw();
    for (int c = 1; c <= done; c++) begin
      @(posedge clk); #1;
      if (lat < 0 && rdy) lat = c;
      if (stbf < 0 && bus.bus_stb) stbf = c;
      exp_rdy   = (c == done);
      exp_stb   = (c >= stb_s) && (c < done);
      exp_req   = (c < done) ? 1'b1 : (lk || op == 4'd3);
      exp_wr    = (op == 4'd2);
      exp_addr  = a;
      exp_wdata = d;
      if (c == done) begin
        if (op != 4'd2) exp_rdata = rd;
        if (op == 4'd3) exp_locked = 1'b1;
      end
      // Busy-time noise: ignored starts and command-input changes,
      // grant outside REQ and acknowledge outside XFER.
      start   = (c < done) ? 1'($urandom_range(0, 1)) : 1'b0;
      opc     = 4'($urandom());
      addr    = AW'($urandom());
      wdata   = rand_dw();
      bus.bus_gnt = (!lk && c == gd + 1) ? 1'b1 :
                    (c >= stb_s) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.bus_ack = (c == stb_s + ad) ? 1'b1 :
                    (c < stb_s || c == done) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.bus_rdata = rand_dw();
      if (c == stb_s + ad) begin
        if (fix_rd) bus.bus_rdata = rd_val;
        rd = bus.bus_rdata;
      end
    end
  endtask

  // Single-cycle command with no bus transaction (opc 0, 4, 5-15) or no
  // start at all; err_clr may accompany it.
  task automatic cmd(input bit st, input logic [3:0] op, input bit clr);
    start = st; opc = op; err_clr = clr;
    addr  = AW'($urandom());
    wdata = rand_dw();
    bus.bus_gnt = 1'($urandom_range(0, 1));
    bus.bus_ack = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    if (st && op >= 4'd5) exp_err = 1'b1;
    else if (clr)         exp_err = 1'b0;
    if (st && op == 4'd4) begin
      exp_locked = 1'b0;
      exp_req    = 1'b0;
    end
    start = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stbf, r;
    logic [3:0] op;
    reset = 1'b1; start = 1'b0; opc = '0; addr = '0; wdata = '0;
    err_clr = 1'b0;
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b0; bus.bus_rdata = '0;
    set_reset_exp();
    #1;
    chk_en = 1'b1;
    #1;
    check("rst_rdy",       DW'(rdy),           DW'(1'b1));
    check("rst_req",       DW'(bus.bus_req),   DW'(1'b0));
    check("rst_stb",       DW'(bus.bus_stb),   DW'(1'b0));
    check("rst_wr",        DW'(bus.bus_wr),    DW'(1'b0));
    check("rst_bus_addr",  DW'(bus.bus_addr),  '0);
    check("rst_bus_wdata", bus.bus_wdata,      '0);
    check("rst_rdata",     rdata,              '0);
    check("rst_err",       DW'(err),           DW'(1'b0));
    check("rst_locked",    DW'(locked),        DW'(1'b0));
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Read, immediate grant/ack.
    run_op(4'd1, 21'h12345, rand_dw(), 0, 0, 1'b1, 72'hA5A5_A5A5_A5A5_A5A5_A5,
           lat, stbf);
    check("read_lat",   DW'(lat),  DW'(3));
    check("read_stb_c", DW'(stbf), DW'(2));
    check("read_rdata", rdata, 72'hA5A5_A5A5_A5A5_A5A5_A5);
    check("read_req",   DW'(bus.bus_req), DW'(1'b0));

    // Write with a 4-cycle strobe before ack.
    run_op(4'd2, 21'h0ABCD, 72'h0F_0123456789ABCDEF, 1, 3, 1'b0, '0, lat, stbf);
    check("write_lat",   DW'(lat), DW'(7));
    check("write_rdata", rdata, 72'hA5A5_A5A5_A5A5_A5A5_A5);

    // Lock sequence.
    run_op(4'd3, 21'h00100, rand_dw(), 1, 1, 1'b0, '0, lat, stbf);
    check("lock_set", DW'(locked),      DW'(1'b1));
    check("lock_req", DW'(bus.bus_req), DW'(1'b1));
    run_op(4'd2, 21'h00101, rand_dw(), 0, 0, 1'b0, '0, lat, stbf);
    check("locked_lat",   DW'(lat),  DW'(2));
    check("locked_stb_c", DW'(stbf), DW'(1));
    check("locked_req",   DW'(bus.bus_req), DW'(1'b1));
    cmd(1'b1, 4'd4, 1'b0);
    check("unlock_locked", DW'(locked),      DW'(1'b0));
    check("unlock_req",    DW'(bus.bus_req), DW'(1'b0));

    // Illegal opcode, clear priority, clear.
    cmd(1'b1, 4'd9, 1'b0);
    check("illegal_err", DW'(err),         DW'(1'b1));
    check("illegal_rdy", DW'(rdy),         DW'(1'b1));
    check("illegal_req", DW'(bus.bus_req), DW'(1'b0));
    cmd(1'b1, 4'd7, 1'b1);
    check("set_wins_err", DW'(err), DW'(1'b1));
    cmd(1'b0, 4'd0, 1'b1);
    check("clear_err", DW'(err), DW'(1'b0));

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 5) begin
        op = 4'($urandom_range(1, 3));
        run_op(op, AW'($urandom()), rand_dw(), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), 1'b0, '0, lat, stbf);
      end else if (r == 6) begin
        cmd(1'b1, 4'd4, 1'($urandom_range(0, 1)));
      end else if (r == 7) begin
        cmd(1'b1, 4'($urandom_range(5, 15)), 1'($urandom_range(0, 1)));
      end else if (r == 8) begin
        cmd(1'b1, 4'd0, 1'($urandom_range(0, 1)));
      end else begin
        cmd(1'b0, 4'($urandom()), 1'($urandom_range(0, 1)));
      end
    end

    // Reset abort in XFER: make sure the bus is free first.
    cmd(1'b1, 4'd4, 1'b0);
    start = 1'b1; opc = 4'd1; addr = 21'h1F00F; wdata = rand_dw();
    bus.bus_gnt = 1'b0; bus.bus_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; bus.bus_gnt = 1'b1;
    exp_rdy = 1'b0; exp_req = 1'b1;
    @(posedge clk); #1;
    bus.bus_gnt = 1'b0;
    exp_stb = 1'b1; exp_wr = 1'b0; exp_addr = 21'h1F00F; exp_wdata = wdata;
    @(posedge clk); #1;
    check("abort_in_xfer", DW'(bus.bus_stb), DW'(1'b1));
    #1;
    set_reset_exp();
    reset = 1'b1;
    #1;
    check("abort_stb", DW'(bus.bus_stb), DW'(1'b0));
    check("abort_req", DW'(bus.bus_req), DW'(1'b0));
    check("abort_rdy", DW'(rdy),         DW'(1'b1));
    @(posedge clk); #1;
    reset = 1'b0;

    // Post-reset sanity.
    run_op(4'd1, 21'h00042, rand_dw(), 0, 0, 1'b0, '0, lat, stbf);
    check("post_reset_lat", DW'(lat), DW'(3));
    run_op(4'd2, 21'h00043, rand_dw(), 2, 1, 1'b0, '0, lat, stbf);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/membus_arbiter_ctl.md
Name: membus_arbiter_ctl

Overview:
Common-bus access controller that sits directly downstream of the CPU microengine. It consumes the arbiter opcode (ARBOPC), the effective address (ADRREG plus physical page) and write data from the BOI. It runs one memory transaction on the shared bus via request/grant/strobe/acknowledge. It returns read data and the ARBRDY condition, which the microsequencer condition multiplexer tests (COND=21).

Parameters:
AW, 21, physical address width (10-bit page + 11-bit offset)
DW, 72, data width (64 data + 8 tag, BOI word)
TMO, 255, bus timeout in clocks (used only with ARB_TIMEOUT_EN)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
start  input  1  one-cycle command strobe from microinstruction ARBI decode
opc  input  4  arbiter opcode (ARBOPC): 0 NOP, 1 READ, 2 WRITE, 3 READ_LOCK, 4 UNLOCK, 5-15 illegal
addr  input  AW  physical address, sampled with start
wdata  input  DW  write data, sampled with start
err_clr  input  1  clears err
rdy  output  1  ARBRDY: idle, ready to accept start
rdata  output  DW  last read data, held until next completed read
err  output  1  sticky error flag
locked  output  1  bus lock held
bus_req  output  1  bus request to system arbiter
bus_gnt  input  1  bus grant
bus_stb  output  1  transfer strobe
bus_wr  output  1  1=write, 0=read; valid while bus_stb
bus_addr  output  AW  transfer address
bus_wdata  output  DW  transfer write data
bus_rdata  input  DW  read data, valid with bus_ack
bus_ack  input  1  transfer acknowledge

Behaviour:
- Reset (async, immediate): state IDLE; rdy=1; bus_req=0; bus_stb=0; bus_wr=0; bus_addr=0; bus_wdata=0; rdata=0; err=0; locked=0. A reset during a transaction drops bus_req/bus_stb at once; no completion is reported.
- All outputs are registered. States: IDLE, REQ, XFER.
- IDLE, start=1, rdy=1:
  - opc 1/2/3: latch addr, wdata, opc; rdy<=0.
    - locked=0: go to REQ with bus_req<=1.
    - locked=1: go directly to XFER with bus_stb<=1; grant is already held.
  - opc 0: no effect.
  - opc 4: locked<=0 and bus_req<=0 next cycle; rdy stays 1.
  - opc 5-15: err<=1; rdy stays 1; no bus activity.
- start while rdy=0 is ignored. Microcode must poll ARBRDY.
- REQ: hold bus_req=1. When bus_gnt is sampled 1, go to XFER with bus_stb<=1 and bus_addr/bus_wr/bus_wdata driven from the latches. bus_wr=1 only for opc 2.
- XFER: hold bus_stb and bus fields stable until bus_ack is sampled 1. Then:
  - read (1/3): rdata<=bus_rdata.
  - bus_stb<=0; rdy<=1; state IDLE.
  - opc 3: locked<=1 and bus_req stays 1.
  - otherwise bus_req<=0, unless locked was already 1.
- Latency: start at cycle 0 with gnt and ack returned immediately gives bus_req=1 in cycle 1, bus_stb=1 in cycle 2, rdy=1 and rdata valid in cycle 3. A locked access takes 2 cycles.
- bus_ack outside XFER and bus_gnt outside REQ are ignored.
- err: sticky. err_clr clears it next cycle. If err_clr coincides with a new error, set wins.
- The system arbiter must hold bus_gnt while bus_req=1. The block does not re-check grant in XFER.

Optional Feature:
ARB_TIMEOUT_EN
- Defined: an 8-bit-or-wider counter is cleared on entry to REQ or XFER and increments each cycle in those states.
- On reaching TMO the transaction aborts:
  - bus_req<=0, bus_stb<=0, locked<=0, err<=1;
  - on a read, rdata<=all ones;
  - rdy<=1; state IDLE.
- If bus_gnt or bus_ack arrives in the same cycle the count reaches TMO, the transaction completes normally.
- Undefined: no counter; the block waits indefinitely in REQ/XFER.

Test Plan:
- Read, immediate gnt/ack: start, opc=1, addr=0x12345, bus_rdata=0xA5...A5 -> bus_req in cycle 1, bus_stb/bus_wr=0 in cycle 2, rdy=1 and rdata=0xA5...A5 in cycle 3, bus_req=0.
- Write with 4-cycle ack delay: opc=2, wdata=0x0F_0123456789ABCDEF -> bus_wr=1, bus_wdata stable for 4 cycles, rdy rises 1 cycle after ack, rdata unchanged.
- Lock sequence: opc=3, then opc=2, then opc=4 -> locked=1 after first ack; bus_req stays 1; second op has no REQ state (2-cycle latency); UNLOCK drops locked and bus_req next cycle.
- Illegal opcode and clear: opc=9 -> err=1, rdy stays 1, no bus_req. err_clr=1 with opc=7 in the same cycle -> err stays 1. Then err_clr alone -> err=0.
- Ignored start and reset abort: a second start while rdy=0 has no effect. Asserting reset in XFER drops bus_stb/bus_req the same cycle and returns rdy=1.
- Timeout (ARB_TIMEOUT_EN, TMO=255): bus_gnt never asserted -> after 255 cycles bus_req=0, err=1, rdy=1. Read abort -> rdata=all ones.
